// File: rtl/hmac_block_feeder_if.sv
// Message-stream and HMAC-core command signals shared by the block feeder and its neighbours.
// The feeder side uses the master modport; the front end / core side uses slave.
interface hmac_block_feeder_if;
   logic          msg_valid;
   logic          msg_ready;
   logic [31:0]   msg_data;
   logic          msg_last;
   logic [1:0]    msg_last_bytes;
   logic          core_init;
   logic          core_next;
   logic          core_ready;
   logic [1023:0] core_block;
   logic          tag_done;
   logic          busy;

   modport master (
      input  msg_valid, msg_data, msg_last, msg_last_bytes, core_ready,
      output msg_ready, core_init, core_next, core_block, tag_done, busy
   );

   modport slave (
      output msg_valid, msg_data, msg_last, msg_last_bytes, core_ready,
      input  msg_ready, core_init, core_next, core_block, tag_done, busy
   );
endinterface

// File: rtl/hmac_block_feeder.sv
// Packs a big-endian word stream into 1024-bit SHA-384 blocks, applies final padding
// (length includes a LEN_OFFSET_BITS prefix) and drives the HMAC core one block at a time.
module hmac_block_feeder #(
   parameter int LEN_OFFSET_BITS = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 zeroize,
   hmac_block_feeder_if.master  bus
);
   typedef enum logic [2:0] {FILL, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

   state_t        state_reg;
   logic [31:0]   buffer_reg [32];
   logic [4:0]    word_idx_reg;
   logic [63:0]   byte_cnt_reg;
   logic          first_blk_reg;
   logic          len_blk_pend_reg;
   logic          pad_in_len_reg;
   logic          final_blk_reg;

   logic [2:0]    valid_bytes;
   logic [63:0]   byte_cnt_next;
   logic [63:0]   len_bits_next;
   logic [63:0]   len_bits_cur;
   logic [31:0]   last_word;
   logic [5:0]    pad_idx;

   always_comb begin
      valid_bytes = 3'd4;
      if (bus.msg_last && bus.msg_last_bytes != 2'd0)
         valid_bytes = {1'b0, bus.msg_last_bytes};
   end

   assign byte_cnt_next = byte_cnt_reg + 64'(valid_bytes);
   assign len_bits_next = (byte_cnt_next << 3) + 64'(LEN_OFFSET_BITS);
   assign len_bits_cur  = (byte_cnt_reg << 3) + 64'(LEN_OFFSET_BITS);
   // pad_idx is the word that receives the 0x80 marker; 32 means it spills into the next block
   assign pad_idx       = {1'b0, word_idx_reg} + ((valid_bytes == 3'd4) ? 6'd1 : 6'd0);

   always_comb begin
      last_word = bus.msg_data;
      case (valid_bytes)
         3'd1:    last_word = {bus.msg_data[31:24], 24'h80_0000};
         3'd2:    last_word = {bus.msg_data[31:16], 16'h8000};
         3'd3:    last_word = {bus.msg_data[31:8], 8'h80};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= FILL;
         for (int i = 0; i < 32; i++) buffer_reg[i] <= '0;
         word_idx_reg     <= '0;
         byte_cnt_reg     <= '0;
         first_blk_reg    <= 1'b1;
         len_blk_pend_reg <= 1'b0;
         pad_in_len_reg   <= 1'b0;
         final_blk_reg    <= 1'b0;
      end else if (zeroize) begin
         state_reg        <= FILL;
         for (int i = 0; i < 32; i++) buffer_reg[i] <= '0;
         word_idx_reg     <= '0;
         byte_cnt_reg     <= '0;
         first_blk_reg    <= 1'b1;
         len_blk_pend_reg <= 1'b0;
         pad_in_len_reg   <= 1'b0;
         final_blk_reg    <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               if (bus.msg_valid) begin
                  byte_cnt_reg <= byte_cnt_next;
                  word_idx_reg <= word_idx_reg + 5'd1;
                  if (!bus.msg_last) begin
                     buffer_reg[word_idx_reg] <= bus.msg_data;
                     if (word_idx_reg == 5'd31)
                        state_reg <= ISSUE;
                  end else begin
                     buffer_reg[word_idx_reg] <= last_word;
                     if (valid_bytes == 3'd4 && word_idx_reg != 5'd31)
                        buffer_reg[word_idx_reg + 5'd1] <= 32'h8000_0000;
                     if (pad_idx <= 6'd27) begin
                        buffer_reg[30] <= len_bits_next[63:32];
                        buffer_reg[31] <= len_bits_next[31:0];
                        final_blk_reg  <= 1'b1;
                     end else begin
                        len_blk_pend_reg <= 1'b1;
                        pad_in_len_reg   <= pad_idx[5];
                     end
                     state_reg <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (bus.core_ready) begin
                  first_blk_reg <= 1'b0;
                  state_reg     <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!bus.core_ready)
                  state_reg <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (bus.core_ready) begin
                  for (int i = 0; i < 32; i++) buffer_reg[i] <= '0;
                  word_idx_reg <= '0;
                  if (final_blk_reg) begin
                     state_reg <= DONE;
                  end else if (len_blk_pend_reg) begin
                     // trailing block carrying only the length (and possibly the pad marker)
                     buffer_reg[0]    <= pad_in_len_reg ? 32'h8000_0000 : 32'h0;
                     buffer_reg[30]   <= len_bits_cur[63:32];
                     buffer_reg[31]   <= len_bits_cur[31:0];
                     len_blk_pend_reg <= 1'b0;
                     pad_in_len_reg   <= 1'b0;
                     final_blk_reg    <= 1'b1;
                     state_reg        <= ISSUE;
                  end else begin
                     state_reg <= FILL;
                  end
               end
            end
            DONE: begin
               first_blk_reg <= 1'b1;
               byte_cnt_reg  <= '0;
               final_blk_reg <= 1'b0;
               state_reg     <= FILL;
            end
            default: state_reg <= FILL;
         endcase
      end
   end

   // Command is gated by core_ready in the same cycle so it can fire the cycle ISSUE is entered
   assign bus.core_init = (state_reg == ISSUE) && bus.core_ready && first_blk_reg;
   assign bus.core_next = (state_reg == ISSUE) && bus.core_ready && !first_blk_reg;
   assign bus.msg_ready = (state_reg == FILL);
   assign bus.tag_done  = (state_reg == DONE);
   assign bus.busy      = (state_reg != FILL);

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_block
         assign bus.core_block[1023 - 32*gi -: 32] = buffer_reg[gi];
      end
   endgenerate
endmodule

// File: doc/hmac_block_feeder.md
# hmac_block_feeder

Upstream initiator for the HMAC-384 core. Accepts a byte-granular message as a stream of 32-bit big-endian words, packs it into 1024-bit blocks, and applies SHA-384 final padding with a length field that includes the key||ipad prefix block. Drives the core's init/next command handshake one block at a time, then signals when the final tag is available. Sits between the register/DMA front end and the HMAC core.

## Interface
- LEN_OFFSET_BITS, default 1024: bits already hashed ahead of the message (the key^ipad block); added to the message bit count in the length field.
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- zeroize  input  1  synchronous clear of all state, including the block buffer.
- msg_valid  input  1  msg_data is valid.
- msg_ready  output  1  the feeder accepts a word when msg_valid & msg_ready.
- msg_data  input  32  message word; the first byte is in [31:24].
- msg_last  input  1  this is the final word of the message.
- msg_last_bytes  input  2  valid bytes in the final word: 1, 2 or 3; 0 means 4. Left-justified. Ignored unless msg_last.
- core_init  output  1  one-cycle command pulse for the first block.
- core_next  output  1  one-cycle command pulse for each later block.
- core_ready  input  1  the core is idle.
- core_block  output  1024  block presented to the core; word 0 is at [1023:992].
- tag_done  output  1  one-cycle pulse; the core's tag is final.
- busy  output  1  high in any state except FILL.

## Operation
- States: FILL, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- Registers: 32×32 buffer, 5-bit word_idx, 64-bit byte_cnt, first_blk, len_blk_pend.
- **FILL** (msg_ready=1):
  - An accepted word is written at word_idx. word_idx increments and byte_cnt adds the valid bytes.
  - Writing word 31 without msg_last → ISSUE.
- **msg_last handling** (same cycle the last word is accepted):
  - Unused bytes of the last word are zeroed.
  - If fewer than 4 bytes are valid, 0x80 goes in the first unused byte of that word; pad_idx = idx. If 4 bytes are valid, 0x80000000 goes at idx+1; pad_idx = idx+1.
  - If pad_idx ≤ 27: words 28..31 = {64'b0, LEN}, where LEN = byte_cnt_final×8 + LEN_OFFSET_BITS. This is the final block.
  - If 28 ≤ pad_idx ≤ 31: the pad byte goes in this block and words 28..31 stay zero. Set len_blk_pend.
  - If pad_idx = 32: set len_blk_pend and mark the pad byte for word 0 of the extra block.
  - Go to ISSUE.
- **ISSUE**:
  - Wait for core_ready=1, then pulse core_init if first_blk, else core_next. Clear first_blk.
  - Go to WAIT_BUSY.
- **WAIT_BUSY**: wait for core_ready=0, then go to WAIT_DONE.
- **WAIT_DONE**: wait for core_ready=1.
  - Clear the buffer and word_idx to 0.
  - If the block just sent was final → DONE.
  - If len_blk_pend → load the length block (zeros, optional 0x80000000 at word 0, LEN in [127:0]), clear len_blk_pend, mark it final, and go to ISSUE.
  - Otherwise → FILL.
- **DONE**:
  - Pulse tag_done. Reset first_blk=1 and byte_cnt=0.
  - Go to FILL.
- core_block always equals the buffer, so it is held stable from the command pulse until WAIT_DONE exits.
- Words offered outside FILL stall (msg_ready=0) and are never dropped.
- Empty messages are not supported. byte_cnt wraps modulo 2^64, which is out of scope.
- reset or zeroize: state=FILL, buffer=0, word_idx=0, byte_cnt=0, first_blk=1, len_blk_pend=0. zeroize has priority over all other activity, and no tag_done is issued for the aborted message.

## Timing
- Reset values: msg_ready=1, core_init=0, core_next=0, core_block=0, tag_done=0, busy=0.
- One word is accepted per cycle in FILL.
- A block completes at cycle T (word 31 or msg_last). ISSUE runs at T+1, and the command pulses at T+1 if core_ready=1.
- The command pulse never occurs while core_ready=0. core_init and core_next are never high together.
- tag_done occurs exactly one cycle after core_ready returns high following the final block's command.
- A new message may begin in the cycle after tag_done.

## Test plan
- One word 0x61626300, last, bytes=3:
  - Single core_init.
  - core_block[1023:992]=0x61626380, all other words 0, [127:0]=0x418.
  - One tag_done pulse.
- 28 full words, last bytes=0:
  - Block 1 via core_init: word 28=0x80000000, [127:0]=0.
  - Block 2 via core_next: all zero except [127:0]=0x780.
- 32 words, then 0xAABB0000 with last, bytes=2:
  - Block 1 via core_init, no padding.
  - Block 2 via core_next: word 0=0xAABB8000, [127:0]=0x810.
- 32 words, last on word 31 with bytes=0:
  - Block 2 via core_next: word 0=0x80000000, [127:0]=0x800.
- Backpressure: msg_valid held high while core_ready is held 0 for 50 cycles.
  - msg_ready stays 0 and no command pulses.
  - All words appear in order once the core is released.
- zeroize during WAIT_DONE, and separately reset during ISSUE:
  - Next cycle (reset: immediately): FILL, core_block=0, no tag_done.
  - The next message starts with core_init.
